// File: rtl/uart_param_pkg.sv
// Shared types and constants for the uart_param UART: FSM states, oversampling
// constants, receive status bit positions and the parity helper.
package uart_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE   = 16;
    localparam int MID_TICK     = 7;
    localparam int SAMPLE_TICK  = 15;

    localparam int STAT_OVERRUN = 2;
    localparam int STAT_PARITY  = 1;
    localparam int STAT_FRAME   = 0;

    // Even parity when odd=0; callers zero-extend narrower words.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_param_fifo.sv
// Show-ahead FIFO with occupancy output; head reads as zero while empty.
module uart_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == FULL_LVL);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the same-cycle pop frees a slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised UART with TX/RX FIFOs and 16x oversampling.
// Define UART_PARITY_EN to add the parity_odd input and a parity bit per frame.
module uart_param
    import uart_param_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
    input  logic                          stop2,
`ifdef UART_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          tx,
    input  logic                          rx,
    input  logic                          wr_uart,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          tx_full,
    input  logic                          rd_uart,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          rx_empty,
    output logic [2:0]                    rx_status,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    logic w_par_odd;
    assign w_par_odd = parity_odd;
`else
    localparam logic PAR_EN = 1'b0;
    logic w_par_odd;
    assign w_par_odd = 1'b0;
`endif

    localparam logic [4:0] TX_LAST  = 5'(SAMPLE_TICK);
    localparam logic [4:0] TX_LAST2 = 5'(2 * OVERSAMPLE - 1);
    localparam logic [3:0] RX_MID   = 4'(MID_TICK);
    localparam logic [3:0] RX_SMP   = 4'(SAMPLE_TICK);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [DIV_W-1:0]     r_tick_cnt;
    logic                 w_tick;
    uart_state_e          r_tx_state, r_rx_state;
    logic                 r_tx, r_tx_stop2, r_tx_par;
    logic [4:0]           r_tx_tick;
    logic [2:0]           r_tx_bit, r_rx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, r_rx_shift, w_tx_head;
    logic                 w_tx_empty, w_tx_pop;
    logic                 r_rx_s1, r_rx_s2, r_rx_d, w_rx_fall;
    logic [3:0]           r_rx_tick;
    logic                 r_par_err, r_overrun;
    logic                 w_rx_push, w_rx_full, w_rx_accept;
    logic [2:0]           w_rx_stat;
    logic [DATA_BITS+2:0] w_rx_head;

    // Reset asserts asynchronously and releases after two clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Oversample tick: down-counter reloaded from divisor only at wrap.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n)    r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= divisor;
        else             r_tick_cnt <= r_tick_cnt - 1'b1;
    end
    assign w_tick = (r_tick_cnt == '0);

    assign w_tx_pop = (r_tx_state == ST_IDLE) & ~w_tx_empty;

    uart_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(clock), .i_rst_n(w_rst_n), .i_push(wr_uart), .i_pop(w_tx_pop),
        .i_data(data_in), .o_data(w_tx_head), .o_full(tx_full),
        .o_empty(w_tx_empty), .o_level(tx_level)
    );

    // Transmit FSM; tx is driven straight from r_tx.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx       <= 1'b1;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_stop2 <= 1'b0;
            r_tx_par   <= 1'b0;
        end else begin
            case (r_tx_state)
                ST_IDLE: if (!w_tx_empty) begin
                    r_tx_state <= ST_START;
                    r_tx       <= 1'b0;
                    r_tx_tick  <= '0;
                    r_tx_shift <= w_tx_head;
                    r_tx_stop2 <= stop2;
                    r_tx_par   <= calc_parity(8'(w_tx_head), w_par_odd);
                end
                ST_START: if (w_tick) begin
                    if (r_tx_tick == TX_LAST) begin
                        r_tx_tick  <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= ST_DATA;
                        r_tx       <= r_tx_shift[0];
                    end else r_tx_tick <= r_tx_tick + 1'b1;
                end
                ST_DATA: if (w_tick) begin
                    if (r_tx_tick == TX_LAST) begin
                        r_tx_tick <= '0;
                        if (r_tx_bit == BIT_LAST) begin
                            r_tx_state <= PAR_EN ? ST_PARITY : ST_STOP;
                            r_tx       <= PAR_EN ? r_tx_par : 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else r_tx_tick <= r_tx_tick + 1'b1;
                end
                ST_PARITY: if (w_tick) begin
                    if (r_tx_tick == TX_LAST) begin
                        r_tx_tick  <= '0;
                        r_tx_state <= ST_STOP;
                        r_tx       <= 1'b1;
                    end else r_tx_tick <= r_tx_tick + 1'b1;
                end
                ST_STOP: if (w_tick) begin
                    if (r_tx_tick == (r_tx_stop2 ? TX_LAST2 : TX_LAST)) begin
                        r_tx_tick  <= '0;
                        r_tx_state <= ST_IDLE;
                    end else r_tx_tick <= r_tx_tick + 1'b1;
                end
                default: begin
                    r_tx_state <= ST_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end
    assign tx = r_tx;

    // rx synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end
    assign w_rx_fall = r_rx_d & ~r_rx_s2;

    // Receive FSM; the 4-bit tick counter wraps 15->0 to align bit periods.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_par_err  <= 1'b0;
        end else begin
            case (r_rx_state)
                ST_IDLE: if (w_rx_fall) begin
                    r_rx_state <= ST_START;
                    r_rx_tick  <= '0;
                    r_par_err  <= 1'b0;
                end
                ST_START: if (w_tick) begin
                    if (r_rx_tick == RX_MID) begin
                        r_rx_tick  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end else r_rx_tick <= r_rx_tick + 1'b1;
                end
                ST_DATA: if (w_tick) begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == RX_SMP) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == BIT_LAST) r_rx_state <= PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: if (w_tick) begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == RX_SMP) begin
                        r_par_err  <= (r_rx_s2 != calc_parity(8'(r_rx_shift), w_par_odd));
                        r_rx_state <= ST_STOP;
                    end
                end
                ST_STOP: if (w_tick) begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == RX_SMP) r_rx_state <= ST_IDLE;
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rx_push   = (r_rx_state == ST_STOP) & w_tick & (r_rx_tick == RX_SMP);
    assign w_rx_accept = ~w_rx_full | rd_uart;

    // Status word for the frame completing this cycle.
    always_comb begin
        w_rx_stat               = 3'b000;
        w_rx_stat[STAT_OVERRUN] = r_overrun;
        w_rx_stat[STAT_PARITY]  = r_par_err;
        w_rx_stat[STAT_FRAME]   = ~r_rx_s2;
    end

    // Sticky overrun: set by a dropped frame, cleared by the next stored one.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n)       r_overrun <= 1'b0;
        else if (w_rx_push) r_overrun <= ~w_rx_accept;
        else                r_overrun <= r_overrun;
    end

    uart_param_fifo #(.WIDTH(DATA_BITS + 3), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(clock), .i_rst_n(w_rst_n), .i_push(w_rx_push), .i_pop(rd_uart),
        .i_data({w_rx_stat, r_rx_shift}), .o_data(w_rx_head), .o_full(w_rx_full),
        .o_empty(rx_empty), .o_level(rx_level)
    );

    assign data_out  = w_rx_head[DATA_BITS-1:0];
    assign rx_status = w_rx_head[DATA_BITS+2:DATA_BITS];

endmodule
